// File: rtl/rv32i_types.sv
// ============================================================================
// Module      : rv32i_types (package)
// Description : Shared RV32I load/store encodings, MEM-stage FSM state and
//               small lane helpers used by the data-memory controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package rv32i_types;

    localparam int C_XLEN = 32;

    typedef enum logic [2:0] {
        LB  = 3'b000,
        LH  = 3'b001,
        LW  = 3'b010,
        LBU = 3'b100,
        LHU = 3'b101
    } load_funct3_t;

    typedef enum logic [2:0] {
        SB = 3'b000,
        SH = 3'b001,
        SW = 3'b010
    } store_funct3_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } dmem_state_t;

    // size is funct3[1:0]: 00 byte, 01 half, 10 word
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
        is_misaligned = ((size == 2'b01) && off[0]) || ((size == 2'b10) && (off != 2'b00));
    endfunction

    function automatic logic [3:0] store_mbe(input logic [2:0] funct3, input logic [1:0] off);
        case (funct3)
            SB:      store_mbe = 4'b0001 << off;
            SH:      store_mbe = 4'b0011 << {off[1], 1'b0};
            default: store_mbe = 4'b1111;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/mem_stage_dmem_ctrl_if.sv
// ============================================================================
// Module      : mem_stage_dmem_ctrl_if
// Description : EXMEM request fields, dmem bus and MEMWB-facing results of
//               the MEM-stage data-memory controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mem_stage_dmem_ctrl_if;
    import rv32i_types::*;

    logic              ex_valid;
    logic              ex_load;
    logic              ex_store;
    logic [2:0]        ex_funct3;
    logic [C_XLEN-1:0] ex_addr;
    logic [C_XLEN-1:0] ex_store_data;
    logic              pipe_adv;

    logic              dmem_read;
    logic              dmem_write;
    logic [C_XLEN-1:0] dmem_addr;
    logic [C_XLEN-1:0] dmem_wdata;
    logic [3:0]        dmem_mbe;
    logic              dmem_resp;
    logic [C_XLEN-1:0] dmem_rdata;

    logic [C_XLEN-1:0] mem_rdata;
    logic              mem_stall;
    logic              misaligned;

    modport master (
        input  ex_valid, ex_load, ex_store, ex_funct3, ex_addr, ex_store_data, pipe_adv,
        input  dmem_resp, dmem_rdata,
        output dmem_read, dmem_write, dmem_addr, dmem_wdata, dmem_mbe,
        output mem_rdata, mem_stall, misaligned
    );

    modport slave (
        output ex_valid, ex_load, ex_store, ex_funct3, ex_addr, ex_store_data, pipe_adv,
        output dmem_resp, dmem_rdata,
        input  dmem_read, dmem_write, dmem_addr, dmem_wdata, dmem_mbe,
        input  mem_rdata, mem_stall, misaligned
    );

endinterface

`default_nettype wire

// File: rtl/mem_load_align.sv
// ============================================================================
// Module      : mem_load_align
// Description : Extracts the addressed byte/half/word from a memory word and
//               sign- or zero-extends it according to the load funct3.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_load_align
    import rv32i_types::*;
(
    input  wire [C_XLEN-1:0] i_rdata,
    input  wire [1:0]        i_off,
    input  wire [2:0]        i_funct3,
    output logic [C_XLEN-1:0] o_result
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        case (i_off)
            2'd0:    w_byte = i_rdata[7:0];
            2'd1:    w_byte = i_rdata[15:8];
            2'd2:    w_byte = i_rdata[23:16];
            default: w_byte = i_rdata[31:24];
        endcase
        w_half = i_off[1] ? i_rdata[31:16] : i_rdata[15:0];

        case (i_funct3)
            LB:      o_result = {{24{w_byte[7]}}, w_byte};
            LBU:     o_result = {24'd0, w_byte};
            LH:      o_result = {{16{w_half[15]}}, w_half};
            LHU:     o_result = {16'd0, w_half};
            default: o_result = i_rdata;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/mem_stage_dmem_ctrl.sv
// ============================================================================
// Module      : mem_stage_dmem_ctrl
// Description : MEM-stage data-memory initiator: issues one dmem request per
//               EXMEM load/store, stalls until the response, aligns results.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_stage_dmem_ctrl
    import rv32i_types::*;
#(
    parameter int XLEN = C_XLEN
) (
    input wire                    clk,
    input wire                    rst,
    mem_stage_dmem_ctrl_if.master bus
);

    dmem_state_t     state_q, state_d;
    logic            read_q, read_d;
    logic            write_q, write_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [XLEN-1:0] wdata_q, wdata_d;
    logic [XLEN-1:0] rdata_q, rdata_d;
    logic [3:0]      mbe_q, mbe_d;
    logic [2:0]      funct3_q, funct3_d;
    logic [1:0]      off_q, off_d;

    logic            w_access;
    logic            w_misaligned;
    logic            w_mem_op;
    logic [XLEN-1:0] w_load_result;

    assign w_access     = bus.ex_valid & (bus.ex_load | bus.ex_store);
    assign w_misaligned = w_access & is_misaligned(bus.ex_funct3[1:0], bus.ex_addr[1:0]);
    assign w_mem_op     = w_access & ~w_misaligned;

    // Alignment works from the latched lane/width, since EXMEM may change once DONE is left
    mem_load_align u_load_align (
        .i_rdata  (bus.dmem_rdata),
        .i_off    (off_q),
        .i_funct3 (funct3_q),
        .o_result (w_load_result)
    );

    always_comb begin
        state_d  = state_q;
        read_d   = read_q;
        write_d  = write_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        mbe_d    = mbe_q;
        funct3_d = funct3_q;
        off_d    = off_q;

        case (state_q)
            IDLE: begin
                if (w_mem_op) begin
                    read_d   = bus.ex_load;
                    write_d  = ~bus.ex_load;
                    addr_d   = {bus.ex_addr[XLEN-1:2], 2'b00};
                    funct3_d = bus.ex_funct3;
                    off_d    = bus.ex_addr[1:0];
                    if (bus.ex_load) begin
                        mbe_d   = 4'b1111;
                        wdata_d = '0;
                    end else begin
                        mbe_d   = store_mbe(bus.ex_funct3, bus.ex_addr[1:0]);
                        wdata_d = bus.ex_store_data << {bus.ex_addr[1:0], 3'b000};
                    end
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (bus.dmem_resp) begin
                    read_d  = 1'b0;
                    write_d = 1'b0;
                    addr_d  = '0;
                    wdata_d = '0;
                    mbe_d   = 4'b0000;
                    rdata_d = read_q ? w_load_result : '0;
                    state_d = DONE;
                end
            end
            DONE: begin
                // Clearing here keeps mem_rdata at 0 for a following misaligned access
                if (bus.pipe_adv) begin
                    rdata_d = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            read_q   <= 1'b0;
            write_q  <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            mbe_q    <= 4'b0000;
            funct3_q <= 3'b000;
            off_q    <= 2'b00;
        end else begin
            state_q  <= state_d;
            read_q   <= read_d;
            write_q  <= write_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            mbe_q    <= mbe_d;
            funct3_q <= funct3_d;
            off_q    <= off_d;
        end
    end

    assign bus.dmem_read  = read_q;
    assign bus.dmem_write = write_q;
    assign bus.dmem_addr  = addr_q;
    assign bus.dmem_wdata = wdata_q;
    assign bus.dmem_mbe   = mbe_q;
    assign bus.mem_rdata  = rdata_q;
    assign bus.mem_stall  = (state_q == BUSY) | ((state_q == IDLE) & w_mem_op);
    assign bus.misaligned = w_misaligned;

endmodule

`default_nettype wire

// File: tb/tb_mem_stage_dmem_ctrl.sv
// ============================================================================
// Module      : tb_mem_stage_dmem_ctrl
// Description : Directed vector bench for the MEM-stage data-memory controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_stage_dmem_ctrl;
    import rv32i_types::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_stage_dmem_ctrl_if bus ();

    mem_stage_dmem_ctrl #(.XLEN(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        string       name;
        logic        ld;
        logic        st;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] sdata;
        logic [31:0] rdata;
        logic        e_rd;
        logic        e_wr;
        logic [31:0] e_addr;
        logic [3:0]  e_mbe;
        logic [31:0] e_wdata;
        logic [31:0] e_rdata;
    } vec_t;

    int n_applied = 0;
    int n_miss    = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_applied++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.ex_valid      = 1'b0;
        bus.ex_load       = 1'b0;
        bus.ex_store      = 1'b0;
        bus.ex_funct3     = 3'b000;
        bus.ex_addr       = 32'h0;
        bus.ex_store_data = 32'h0;
        bus.pipe_adv      = 1'b0;
    endtask

    task automatic drive_op(input vec_t v);
        bus.ex_valid      = 1'b1;
        bus.ex_load       = v.ld;
        bus.ex_store      = v.st;
        bus.ex_funct3     = v.f3;
        bus.ex_addr       = v.addr;
        bus.ex_store_data = v.sdata;
        bus.pipe_adv      = 1'b0;
    endtask

    // Entered just after a rising edge with the controller idle; leaves it idle.
    task automatic run_txn(input vec_t v, input int lat);
        int stalls;
        stalls = 0;
        drive_op(v);
        @(negedge clk);
        if (bus.mem_stall) stalls++;
        chk({v.name, " misaligned"}, 32'(bus.misaligned), 32'd0);
        chk({v.name, " no early req"}, 32'({bus.dmem_read, bus.dmem_write}), 32'd0);
        chk({v.name, " idle rdata"}, bus.mem_rdata, 32'd0);
        for (int c = 0; c < lat; c++) begin
            @(posedge clk); #1;
            @(negedge clk);
            if (bus.mem_stall) stalls++;
            chk({v.name, " read"}, 32'(bus.dmem_read), 32'(v.e_rd));
            chk({v.name, " write"}, 32'(bus.dmem_write), 32'(v.e_wr));
            chk({v.name, " addr"}, bus.dmem_addr, v.e_addr);
            chk({v.name, " mbe"}, 32'(bus.dmem_mbe), 32'(v.e_mbe));
            if (v.e_wr) chk({v.name, " wdata"}, bus.dmem_wdata, v.e_wdata);
            if (c == lat - 1) begin
                bus.dmem_resp  = 1'b1;
                bus.dmem_rdata = v.rdata;
            end
        end
        @(posedge clk); #1;
        bus.dmem_resp  = 1'b0;
        bus.dmem_rdata = 32'h0;
        @(negedge clk);
        if (bus.mem_stall) stalls++;
        chk({v.name, " mem_rdata"}, bus.mem_rdata, v.e_rdata);
        chk({v.name, " req dropped"}, 32'({bus.dmem_read, bus.dmem_write}), 32'd0);
        chk({v.name, " stall cycles"}, 32'(stalls), 32'(lat + 1));
        bus.pipe_adv = 1'b1;
        @(posedge clk); #1;
        idle_inputs();
    endtask

    vec_t vecs[14];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        // name ld st f3 addr sdata rdata | rd wr addr mbe wdata mem_rdata
        vecs[0]  = '{"LW 100",   1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 1'b1, 1'b0, 32'h100, 4'hF, 32'h0, 32'hDEADBEEF};
        vecs[1]  = '{"LB 103",   1'b1, 1'b0, 3'b000, 32'h103, 32'h0, 32'h80FFFFFF, 1'b1, 1'b0, 32'h100, 4'hF, 32'h0, 32'hFFFFFF80};
        vecs[2]  = '{"LBU 103",  1'b1, 1'b0, 3'b100, 32'h103, 32'h0, 32'h80FFFFFF, 1'b1, 1'b0, 32'h100, 4'hF, 32'h0, 32'h00000080};
        vecs[3]  = '{"LHU 102",  1'b1, 1'b0, 3'b101, 32'h102, 32'h0, 32'h80FFFFFF, 1'b1, 1'b0, 32'h100, 4'hF, 32'h0, 32'h000080FF};
        vecs[4]  = '{"LH 102",   1'b1, 1'b0, 3'b001, 32'h102, 32'h0, 32'h80FFFFFF, 1'b1, 1'b0, 32'h100, 4'hF, 32'h0, 32'hFFFF80FF};
        vecs[5]  = '{"LB 101",   1'b1, 1'b0, 3'b000, 32'h101, 32'h0, 32'h12345678, 1'b1, 1'b0, 32'h100, 4'hF, 32'h0, 32'h00000056};
        vecs[6]  = '{"LH 100",   1'b1, 1'b0, 3'b001, 32'h100, 32'h0, 32'h1234F678, 1'b1, 1'b0, 32'h100, 4'hF, 32'h0, 32'hFFFFF678};
        vecs[7]  = '{"LD+ST 300",1'b1, 1'b1, 3'b010, 32'h300, 32'h0, 32'h11223344, 1'b1, 1'b0, 32'h300, 4'hF, 32'h0, 32'h11223344};
        vecs[8]  = '{"SB 201",   1'b0, 1'b1, 3'b000, 32'h201, 32'h123456AB, 32'hFFFFFFFF, 1'b0, 1'b1, 32'h200, 4'h2, 32'h3456AB00, 32'h0};
        vecs[9]  = '{"SH 202",   1'b0, 1'b1, 3'b001, 32'h202, 32'h123456AB, 32'hFFFFFFFF, 1'b0, 1'b1, 32'h200, 4'hC, 32'h56AB0000, 32'h0};
        vecs[10] = '{"SW 204",   1'b0, 1'b1, 3'b010, 32'h204, 32'hCAFEF00D, 32'hFFFFFFFF, 1'b0, 1'b1, 32'h204, 4'hF, 32'hCAFEF00D, 32'h0};
        vecs[11] = '{"SB 203",   1'b0, 1'b1, 3'b000, 32'h203, 32'h000000EE, 32'hFFFFFFFF, 1'b0, 1'b1, 32'h200, 4'h8, 32'hEE000000, 32'h0};
        vecs[12] = '{"SH 200",   1'b0, 1'b1, 3'b001, 32'h200, 32'h0000BEEF, 32'hFFFFFFFF, 1'b0, 1'b1, 32'h200, 4'h3, 32'h0000BEEF, 32'h0};
        vecs[13] = '{"LHU 100",  1'b1, 1'b0, 3'b101, 32'h100, 32'h0, 32'hABCD8001, 1'b1, 1'b0, 32'h100, 4'hF, 32'h0, 32'h00008001};

        rst            = 1'b1;
        bus.dmem_resp  = 1'b0;
        bus.dmem_rdata = 32'h0;
        idle_inputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset read", 32'(bus.dmem_read), 32'd0);
        chk("reset write", 32'(bus.dmem_write), 32'd0);
        chk("reset addr", bus.dmem_addr, 32'd0);
        chk("reset wdata", bus.dmem_wdata, 32'd0);
        chk("reset mbe", 32'(bus.dmem_mbe), 32'd0);
        chk("reset mem_rdata", bus.mem_rdata, 32'd0);
        chk("reset stall", 32'(bus.mem_stall), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Consecutive vectors run back to back; latency varies 3,2,1 (LW 0x100 gets 3)
        foreach (vecs[i]) run_txn(vecs[i], 3 - (i % 3));

        // Misaligned accesses issue nothing
        v = '{"LW 102 mis", 1'b1, 1'b0, 3'b010, 32'h102, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 32'h0};
        drive_op(v);
        @(negedge clk);
        chk("LW 102 misaligned", 32'(bus.misaligned), 32'd1);
        chk("LW 102 stall", 32'(bus.mem_stall), 32'd0);
        chk("LW 102 mem_rdata", bus.mem_rdata, 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("LW 102 no read", 32'(bus.dmem_read), 32'd0);
        chk("LW 102 state", 32'(dut.state_q), 32'(IDLE));
        bus.ex_funct3 = 3'b001;
        bus.ex_addr   = 32'h101;
        #1 chk("LH 101 misaligned", 32'(bus.misaligned), 32'd1);
        bus.ex_addr   = 32'h102;
        #1 chk("LH 102 aligned", 32'(bus.misaligned), 32'd0);
        idle_inputs();
        @(posedge clk); #1;

        // Store completes while the pipeline is held elsewhere
        v = '{"SW 20C", 1'b0, 1'b1, 3'b010, 32'h20C, 32'h0BADF00D, 32'h0, 1'b0, 1'b1, 32'h20C, 4'hF, 32'h0BADF00D, 32'h0};
        drive_op(v);
        @(posedge clk); #1;
        @(negedge clk);
        chk("hold write issued", 32'(bus.dmem_write), 32'd1);
        bus.dmem_resp = 1'b1;
        @(posedge clk); #1;
        bus.dmem_resp = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("hold state", 32'(dut.state_q), 32'(DONE));
            chk("hold no rewrite", 32'(bus.dmem_write), 32'd0);
            chk("hold stall", 32'(bus.mem_stall), 32'd0);
            @(posedge clk); #1;
        end
        @(negedge clk);
        bus.pipe_adv = 1'b1;
        @(posedge clk); #1;
        idle_inputs();
        @(negedge clk);
        chk("hold release state", 32'(dut.state_q), 32'(IDLE));
        chk("hold release write", 32'(bus.dmem_write), 32'd0);
        @(posedge clk); #1;

        // Reset during BUSY abandons the access; the late response is ignored
        v = '{"LW 108", 1'b1, 1'b0, 3'b010, 32'h108, 32'h0, 32'h0, 1'b1, 1'b0, 32'h108, 4'hF, 32'h0, 32'h0};
        drive_op(v);
        @(posedge clk); #1;
        @(negedge clk);
        chk("rstbusy read before", 32'(bus.dmem_read), 32'd1);
        #1;
        rst = 1'b1;
        idle_inputs();
        #1;
        chk("rstbusy read", 32'(bus.dmem_read), 32'd0);
        chk("rstbusy addr", bus.dmem_addr, 32'd0);
        chk("rstbusy mbe", 32'(bus.dmem_mbe), 32'd0);
        chk("rstbusy stall", 32'(bus.mem_stall), 32'd0);
        @(posedge clk); #1;
        rst            = 1'b0;
        bus.dmem_resp  = 1'b1;
        bus.dmem_rdata = 32'h55555555;
        @(posedge clk); #1;
        bus.dmem_resp  = 1'b0;
        bus.dmem_rdata = 32'h0;
        @(negedge clk);
        chk("late resp state", 32'(dut.state_q), 32'(IDLE));
        chk("late resp mem_rdata", bus.mem_rdata, 32'd0);
        chk("late resp read", 32'(bus.dmem_read), 32'd0);
        @(posedge clk); #1;
        v = '{"LW 104 after rst", 1'b1, 1'b0, 3'b010, 32'h104, 32'h0, 32'h0A0B0C0D, 1'b1, 1'b0, 32'h104, 4'hF, 32'h0, 32'h0A0B0C0D};
        run_txn(v, 2);

        $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miss);
        $finish;
    end

endmodule

`default_nettype wire
